// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO for the UART datapath: registered or first-word-fall-through
// read, programmable almost-full/almost-empty thresholds, sticky error flags and an irq.
module uart_sync_fifo #(
   parameter  int DEPTH      = 16,
   parameter  int DATA_WIDTH = 8,
   parameter  int FWFT       = 0,
   localparam int AW         = $clog2(DEPTH),
   localparam int LW         = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   input  logic [LW-1:0]         af_thresh,
   input  logic [LW-1:0]         ae_thresh,
   output logic [LW-1:0]         level,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err,
   output logic                  irq
);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          irq_q, irq_d;
   logic          wr_acc;
   logic          rd_acc;

   // One extra pointer bit distinguishes full from empty; wrap is plain modulo arithmetic.
   assign level        = wr_ptr_q - rd_ptr_q;
   assign full         = (level == DEPTH_L);
   assign empty        = (level == '0);
   assign almost_full  = (level >= af_thresh);
   assign almost_empty = (level <= ae_thresh);
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign irq          = irq_q;

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + LW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + LW'(1);
      // A new error event takes priority over a clear in the same cycle.
      if (wr_en && full)  ovf_d = 1'b1;
      else if (clr_err)   ovf_d = 1'b0;
      if (rd_en && empty) unf_d = 1'b1;
      else if (clr_err)   unf_d = 1'b0;
      irq_d = almost_full | ovf_q | unf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         irq_q    <= irq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem[wr_ptr_q[AW-1:0]] <= wr_data;
   end

   if (FWFT != 0) begin : g_fwft
      assign rd_data  = mem[rd_ptr_q[AW-1:0]];
      assign rd_valid = ~empty;
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
         rd_data_d  = rd_data_q;
         rd_valid_d = rd_acc;
         if (rd_acc) rd_data_d = mem[rd_ptr_q[AW-1:0]];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
   end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: a registered-read and a FWFT instance (DEPTH=4) share stimulus
// and are compared every cycle against a queue-based model, plus directed literal checks.
module tb_uart_sync_fifo;

   localparam int DEPTH = 4;
   localparam int DW    = 8;
   localparam int LW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic          clr_err;
   logic [LW-1:0] af_thresh;
   logic [LW-1:0] ae_thresh;

   logic [DW-1:0] a_rd_data, b_rd_data;
   logic          a_rd_valid, b_rd_valid;
   logic          a_full, b_full, a_empty, b_empty;
   logic          a_af, b_af, a_ae, b_ae;
   logic [LW-1:0] a_level, b_level;
   logic          a_ovf, b_ovf, a_unf, b_unf, a_irq, b_irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) u_reg (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .level(a_level), .overflow(a_ovf), .underflow(a_unf), .clr_err(clr_err), .irq(a_irq)
   );

   uart_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .level(b_level), .overflow(b_ovf), .underflow(b_unf), .clr_err(clr_err), .irq(b_irq)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of words plus the flags the outputs are defined from.
   logic [DW-1:0] mq[$];
   bit            m_ovf, m_unf, m_irq, m_rv;
   logic [DW-1:0] m_rd;
   bit            model_ok = 0;

   always @(posedge clk) begin
      int  n;
      bit  was_full, was_empty;
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_unf = 0; m_irq = 0; m_rv = 0; m_rd = '0;
         model_ok = 1;
      end else if (model_ok) begin
         n         = mq.size();
         was_full  = (n == DEPTH);
         was_empty = (n == 0);
         m_irq     = (n >= int'(af_thresh)) || m_ovf || m_unf;
         if (wr_en && was_full) m_ovf = 1; else if (clr_err) m_ovf = 0;
         if (rd_en && was_empty) m_unf = 1; else if (clr_err) m_unf = 0;
         m_rv = 0;
         if (rd_en && !was_empty) begin
            m_rd = mq.pop_front();
            m_rv = 1;
         end
         if (wr_en && !was_full) mq.push_back(wr_data);
      end
   end

   always @(negedge clk) begin
      int n;
      if (model_ok) begin
         n = mq.size();
         chk("level",        a_level, n);
         chk("level_fwft",   b_level, n);
         chk("full",         a_full, int'(n == DEPTH));
         chk("empty",        a_empty, int'(n == 0));
         chk("empty_fwft",   b_empty, int'(n == 0));
         chk("almost_full",  a_af, int'(n >= int'(af_thresh)));
         chk("almost_empty", a_ae, int'(n <= int'(ae_thresh)));
         chk("overflow",     a_ovf, int'(m_ovf));
         chk("underflow",    a_unf, int'(m_unf));
         chk("irq",          a_irq, int'(m_irq));
         chk("irq_fwft",     b_irq, int'(m_irq));
         chk("rd_valid",     a_rd_valid, int'(m_rv));
         chk("rd_data",      a_rd_data, m_rd);
         chk("rd_valid_fwft", b_rd_valid, int'(n != 0));
         if (n != 0) chk("rd_data_fwft", b_rd_data, mq[0]);
      end
   end

   // Apply one cycle of inputs at negedge+1 and return one negedge+1 later, inputs idle.
   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
      wr_en = w; wr_data = d; rd_en = r; clr_err = c;
      @(negedge clk); #1;
      wr_en = 0; rd_en = 0; clr_err = 0;
   endtask

   initial begin
      rst = 1; wr_en = 0; wr_data = '0; rd_en = 0; clr_err = 0;
      af_thresh = 3'd5; ae_thresh = 3'd0;
      repeat (2) @(negedge clk);
      #1 rst = 0;

      chk("rst_level", a_level, 0);
      chk("rst_empty", a_empty, 1);
      chk("rst_full", a_full, 0);
      chk("rst_ae", a_ae, 1);
      chk("rst_af", a_af, 0);
      chk("rst_rd_valid", a_rd_valid, 0);
      chk("rst_rd_data", a_rd_data, 0);

      // Fill and drain with one-cycle rd_valid per read.
      for (int i = 0; i < 4; i++) cyc(1, DW'(8'h11 * (i + 1)), 0, 0);
      chk("fill_full", a_full, 1);
      chk("fill_level", a_level, 4);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 0);
         chk("drain_valid", a_rd_valid, 1);
         chk("drain_data", a_rd_data, 8'h11 * (i + 1));
         cyc(0, 0, 0, 0);
         chk("drain_valid_drop", a_rd_valid, 0);
         chk("drain_data_hold", a_rd_data, 8'h11 * (i + 1));
      end
      chk("drain_empty", a_empty, 1);

      // Overflow: dropped write, sticky flag, irq one cycle later, clear.
      for (int i = 0; i < 4; i++) cyc(1, DW'(8'h11 * (i + 1)), 0, 0);
      chk("ovf_pre_irq", a_irq, 0);
      cyc(1, 8'h55, 0, 0);
      chk("ovf_set", a_ovf, 1);
      chk("ovf_level", a_level, 4);
      chk("ovf_irq_lat", a_irq, 0);
      cyc(0, 0, 0, 0);
      chk("ovf_irq", a_irq, 1);
      cyc(0, 0, 0, 1);
      chk("ovf_clr", a_ovf, 0);
      cyc(0, 0, 0, 0);
      chk("ovf_irq_clr", a_irq, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 0);
         chk("ovf_drain", a_rd_data, 8'h11 * (i + 1));
      end
      cyc(0, 0, 0, 0);

      // Underflow with a simultaneous write.
      cyc(1, 8'hA5, 1, 0);
      chk("unf_set", a_unf, 1);
      chk("unf_level", a_level, 1);
      cyc(0, 0, 1, 0);
      chk("unf_data", a_rd_data, 8'hA5);
      chk("unf_valid", a_rd_valid, 1);
      cyc(0, 0, 0, 1);
      chk("unf_clr", a_unf, 0);

      // Wrap-around at constant level 2.
      cyc(1, 8'hC0, 0, 0);
      cyc(1, 8'hC1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, DW'(8'hC2 + i), 1, 0);
         chk("wrap_level", a_level, 2);
         chk("wrap_data", a_rd_data, 8'hC0 + i);
      end
      cyc(0, 0, 1, 0);
      chk("wrap_tail0", a_rd_data, 8'hCA);
      cyc(0, 0, 1, 0);
      chk("wrap_tail1", a_rd_data, 8'hCB);
      cyc(0, 0, 0, 0);

      // First-word-fall-through visibility and pop.
      cyc(1, 8'h7E, 0, 0);
      chk("fwft_valid", b_rd_valid, 1);
      chk("fwft_data", b_rd_data, 8'h7E);
      chk("reg_no_valid", a_rd_valid, 0);
      cyc(0, 0, 1, 0);
      chk("fwft_pop", b_rd_valid, 0);
      chk("reg_pop_data", a_rd_data, 8'h7E);

      // Thresholds, then reset mid-stream with requests ignored.
      af_thresh = 3'd3; ae_thresh = 3'd1;
      for (int i = 1; i <= 3; i++) cyc(1, DW'(i), 0, 0);
      chk("thr_af", a_af, 1);
      chk("thr_ae", a_ae, 0);
      cyc(0, 0, 0, 0);
      chk("thr_irq", a_irq, 1);
      rst = 1;
      cyc(1, 8'h99, 1, 0);
      rst = 0;
      chk("midrst_level", a_level, 0);
      chk("midrst_irq", a_irq, 0);
      chk("midrst_empty", b_empty, 1);

      // Randomized traffic with alternating write-heavy and read-heavy phases.
      for (int i = 0; i < 3000; i++) begin
         int wp;
         wp = ((i / 100) % 2 == 0) ? 70 : 30;
         wr_en   = ($urandom_range(0, 99) < wp);
         rd_en   = ($urandom_range(0, 99) < (100 - wp));
         wr_data = DW'($urandom);
         clr_err = ($urandom_range(0, 19) == 0);
         rst     = ($urandom_range(0, 149) == 0);
         if (i % 50 == 0) begin
            af_thresh = LW'($urandom_range(0, 7));
            ae_thresh = LW'($urandom_range(0, 7));
         end
         @(negedge clk); #1;
      end
      rst = 0; wr_en = 0; rd_en = 0; clr_err = 0;
      @(negedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
